// File: rtl/str_class_matcher_if.sv
// Character-class stream, error release, table programming and status bundle
// for str_class_matcher. The master drives characters/config; the slave is the matcher.
interface str_class_matcher_if #(
    parameter int N_STEPS = 4,
    parameter int CNT_W   = 4
);
    localparam int AW = $clog2(N_STEPS);

    logic              valid;
    logic [13:0]       cls;
    logic              error_verify;
    logic              cfg_we;
    logic [AW-1:0]     cfg_addr;
    logic [13:0]       cfg_mask;
    logic [CNT_W-1:0]  cfg_min;
    logic [CNT_W-1:0]  cfg_max;
    logic              cfg_last_we;
    logic [AW-1:0]     cfg_last;
    logic [2:0]        state;
    logic [AW-1:0]     step;
    logic [CNT_W-1:0]  cnt;
    logic              match;
    logic              mismatch;
    logic              busy;

    modport master (
        output valid, cls, error_verify,
        output cfg_we, cfg_addr, cfg_mask, cfg_min, cfg_max, cfg_last_we, cfg_last,
        input  state, step, cnt, match, mismatch, busy
    );

    modport slave (
        input  valid, cls, error_verify,
        input  cfg_we, cfg_addr, cfg_mask, cfg_min, cfg_max, cfg_last_we, cfg_last,
        output state, step, cnt, match, mismatch, busy
    );
endinterface

// File: rtl/str_class_matcher.sv
// Table-driven recogniser for \0-delimited strings of character-class strobes.
// Define STR_CLASS_MATCHER_CFG_EN to make the step table run-time programmable.
module str_class_matcher #(
    parameter int N_STEPS = 4,
    parameter int CNT_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    str_class_matcher_if.slave   bus
);
    localparam int AW = $clog2(N_STEPS);
    localparam logic [AW-1:0] RST_LAST = AW'(3);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STOP  = 3'd2,
        ST_ERROR = 3'd3
    } state_t;

    function automatic logic [13:0] rst_mask(input int s);
        case (s)
            0:       return 14'h0080;
            1:       return 14'h0200;
            2:       return 14'h0008;
            3:       return 14'h0080;
            default: return 14'h0000;
        endcase
    endfunction

    // Reset min and max are identical for every step of the fixed variant.
    function automatic logic [CNT_W-1:0] rst_bound(input int s);
        case (s)
            0, 1, 3: return CNT_W'(1);
            2:       return CNT_W'(2);
            default: return CNT_W'(0);
        endcase
    endfunction

    logic [13:0]      tbl_mask [N_STEPS];
    logic [CNT_W-1:0] tbl_min  [N_STEPS];
    logic [CNT_W-1:0] tbl_max  [N_STEPS];
    logic [AW-1:0]    tbl_last;

    state_t           state_q, state_d;
    logic [AW-1:0]    step_q, step_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             match_q, match_d;
    logic             mismatch_q, mismatch_d;
    logic             busy_q;

`ifdef STR_CLASS_MATCHER_CFG_EN
    logic [13:0]      mask_q [N_STEPS];
    logic [13:0]      mask_d [N_STEPS];
    logic [CNT_W-1:0] min_q  [N_STEPS];
    logic [CNT_W-1:0] min_d  [N_STEPS];
    logic [CNT_W-1:0] max_q  [N_STEPS];
    logic [CNT_W-1:0] max_d  [N_STEPS];
    logic [AW-1:0]    last_q, last_d;
    logic             cfg_open;
    logic             addr_ok;
    logic             last_ok;

    assign cfg_open = (state_q == ST_IDLE);
    assign addr_ok  = ({1'b0, bus.cfg_addr} < (AW+1)'(N_STEPS));
    assign last_ok  = ({1'b0, bus.cfg_last} < (AW+1)'(N_STEPS));

    always_comb begin
        mask_d = mask_q;
        min_d  = min_q;
        max_d  = max_q;
        last_d = last_q;
        if (bus.cfg_we && cfg_open && addr_ok) begin
            mask_d[bus.cfg_addr] = bus.cfg_mask;
            min_d[bus.cfg_addr]  = bus.cfg_min;
            max_d[bus.cfg_addr]  = bus.cfg_max;
        end
        if (bus.cfg_last_we && cfg_open && last_ok) begin
            last_d = bus.cfg_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_STEPS; i++) begin
                mask_q[i] <= rst_mask(i);
                min_q[i]  <= rst_bound(i);
                max_q[i]  <= rst_bound(i);
            end
            last_q <= RST_LAST;
        end else begin
            mask_q <= mask_d;
            min_q  <= min_d;
            max_q  <= max_d;
            last_q <= last_d;
        end
    end

    always_comb begin
        tbl_mask = mask_q;
        tbl_min  = min_q;
        tbl_max  = max_q;
        tbl_last = last_q;
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{bus.cfg_we, bus.cfg_addr, bus.cfg_mask, bus.cfg_min,
                          bus.cfg_max, bus.cfg_last_we, bus.cfg_last};

    always_comb begin
        for (int i = 0; i < N_STEPS; i++) begin
            tbl_mask[i] = rst_mask(i);
            tbl_min[i]  = rst_bound(i);
            tbl_max[i]  = rst_bound(i);
        end
        tbl_last = RST_LAST;
    end
`endif

    // Bit 0 of a mask is the terminator class and never counts as a hit.
    logic [AW-1:0] step_nxt;
    logic          hit_cur;
    logic          hit_nxt;
    logic          is_term;

    assign step_nxt = step_q + AW'(1);
    assign hit_cur  = |(bus.cls & tbl_mask[step_q] & 14'h3FFE);
    assign hit_nxt  = |(bus.cls & tbl_mask[step_nxt] & 14'h3FFE);
    assign is_term  = bus.valid && bus.cls[0];

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        cnt_d      = cnt_q;
        match_d    = 1'b0;
        mismatch_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (is_term) begin
                    state_d = ST_RUN;
                    step_d  = '0;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (is_term) begin
                    if (step_q == tbl_last && cnt_q >= tbl_min[tbl_last]) begin
                        state_d = ST_STOP;
                    end else begin
                        state_d    = ST_IDLE;
                        step_d     = '0;
                        cnt_d      = '0;
                        mismatch_d = 1'b1;
                    end
                end else if (bus.valid) begin
                    // Greedy: staying in the step wins over advancing.
                    if (hit_cur && cnt_q < tbl_max[step_q]) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else if (cnt_q >= tbl_min[step_q] && step_q < tbl_last && hit_nxt) begin
                        step_d = step_nxt;
                        cnt_d  = CNT_W'(1);
                    end else begin
                        state_d    = ST_ERROR;
                        mismatch_d = 1'b1;
                    end
                end
            end
            ST_STOP: begin
                state_d = ST_IDLE;
                step_d  = '0;
                cnt_d   = '0;
                match_d = 1'b1;
            end
            ST_ERROR: begin
                if (bus.error_verify || is_term) begin
                    state_d = ST_IDLE;
                    step_d  = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                step_d  = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            step_q     <= '0;
            cnt_q      <= '0;
            match_q    <= 1'b0;
            mismatch_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            cnt_q      <= cnt_d;
            match_q    <= match_d;
            mismatch_q <= mismatch_d;
            busy_q     <= (state_d != ST_IDLE);
        end
    end

    assign bus.state    = state_q;
    assign bus.step     = step_q;
    assign bus.cnt      = cnt_q;
    assign bus.match    = match_q;
    assign bus.mismatch = mismatch_q;
    assign bus.busy     = busy_q;
endmodule
